// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory responder.
//   mem_rsp_state_t : responder FSM states
//   MEM_WORD_BYTES  : byte lanes per memory word
//   MEM_LAT_W       : width of the wait-state counter (LATENCY 0..15)
//   be_to_mask()    : expands per-byte enables into a 64-bit bit mask
package riscv_pkg;

  localparam int unsigned MEM_WORD_BYTES = 8;
  localparam int unsigned MEM_WORD_W     = MEM_WORD_BYTES * 8;
  localparam int unsigned MEM_LAT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_rsp_state_t;

  function automatic logic [MEM_WORD_W-1:0] be_to_mask(input logic [MEM_WORD_BYTES-1:0] be);
    logic [MEM_WORD_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MEM_WORD_BYTES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_array_1rw.sv
// Single-port word array with per-byte write enables and a registered read
// output; the read register holds its value until the next read access.
//   clk      : clock
//   en_i     : access enable for this cycle
//   we_i     : 1 = write enabled lanes, 0 = read into rdata_o
//   be_i     : byte-lane write enables
//   idx_i    : word index (combinational, sampled at the access edge)
//   wdata_i  : lane-aligned write data
//   rdata_o  : registered read data
module mem_array_1rw
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned INIT_ZERO   = 1
) (
  input  logic                                  clk,
  input  logic                                  en_i,
  input  logic                                  we_i,
  input  logic [MEM_WORD_BYTES-1:0]             be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0]        idx_i,
  input  logic [MEM_WORD_W-1:0]                 wdata_i,
  output logic [MEM_WORD_W-1:0]                 rdata_o
);

  // Power-up contents for simulation; reset never touches the array.
  localparam logic [MEM_WORD_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? '0 : 'x;

  logic [MEM_WORD_W-1:0] mem_q [DEPTH_WORDS] = '{default: INIT_WORD};
  logic [MEM_WORD_W-1:0] rdata_q;
  logic [MEM_WORD_W-1:0] mask_c;

  assign mask_c = be_to_mask(be_i);

  // Write merges enabled lanes; read captures the whole word.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= (mem_q[idx_i] & ~mask_c) | (wdata_i & mask_c);
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: accepts one request at a time on a valid/ready
// channel, waits LATENCY cycles, then presents the response until taken.
//   clk, rst      : clock, synchronous active-high reset
//   req_*_i/_o    : request channel (valid/ready, we, be, byte addr, wdata)
//   rsp_*_i/_o    : response channel (valid/ready, rdata, err)
//   busy_o        : a transaction is in flight
module mem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned INIT_ZERO   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [7:0]  req_be_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W = 61;
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);

  mem_rsp_state_t       state_q, state_d;
  logic [MEM_LAT_W-1:0] cnt_q, cnt_d;

  logic             we_q;
  logic [7:0]       be_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q;

  logic rd_ok_q, rd_ok_d;
  logic err_q, err_d;

  logic             accept_c, enter_resp_c;
  logic             a_we_c, in_range_c, arr_en_c;
  logic [7:0]       a_be_c;
  logic [IDX_W-1:0] a_idx_c;
  logic [63:0]      a_wdata_c;
  logic [63:0]      arr_rdata_c;
  logic             unused_addr_c;

  assign unused_addr_c = ^req_addr_i[2:0];
  assign accept_c      = (state_q == IDLE) && req_valid_i;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; enter_resp_c marks the edge that performs the array access.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY == 0) begin
            state_d      = RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = MEM_LAT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - MEM_LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE:    begin req_ready_o = 1'b1; busy_o = 1'b0; end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request payload captured at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      we_q    <= req_we_i;
      be_q    <= req_be_i;
      idx_q   <= req_addr_i[63:3];
      wdata_q <= req_wdata_i;
    end
  end

  // With zero latency the access happens on the acceptance edge, so the
  // live request is used instead of the not-yet-loaded payload registers.
  always_comb begin
    if (state_q == IDLE) begin
      a_we_c    = req_we_i;
      a_be_c    = req_be_i;
      a_idx_c   = req_addr_i[63:3];
      a_wdata_c = req_wdata_i;
    end else begin
      a_we_c    = we_q;
      a_be_c    = be_q;
      a_idx_c   = idx_q;
      a_wdata_c = wdata_q;
    end
  end

  assign in_range_c = a_idx_c < IDX_W'(DEPTH_WORDS);
  // Gated by rst so a write reaching RESP on a reset edge is not committed.
  assign arr_en_c   = enter_resp_c && in_range_c && !rst;

  // Response qualifiers: rdata is only shown for in-range reads.
  always_comb begin
    rd_ok_d = rd_ok_q;
    err_d   = err_q;
    if (enter_resp_c) begin
      rd_ok_d = in_range_c && !a_we_c;
      err_d   = !in_range_c;
    end else if ((state_q == RESP) && rsp_ready_i) begin
      rd_ok_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rd_ok_q <= rd_ok_d;
      err_q   <= err_d;
    end
  end

  mem_array_1rw #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_ZERO   (INIT_ZERO)
  ) u_array (
    .clk     (clk),
    .en_i    (arr_en_c),
    .we_i    (a_we_c),
    .be_i    (a_be_c),
    .idx_i   (a_idx_c[AW-1:0]),
    .wdata_i (a_wdata_c),
    .rdata_o (arr_rdata_c)
  );

  assign rsp_rdata_o = rd_ok_q ? arr_rdata_c : '0;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2 / 0 / 3, the last with
// a 64-word array) share the request payload and response-ready lines; each
// has its own req_valid. A sparse word map models the memory contents.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  req_valid;
  logic        req_we;
  logic [7:0]  req_be;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_ready;

  logic [2:0]  rdy_v, val_v, err_v, busy_v;
  logic [63:0] rdata_v [3];

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mdl [bit [62:0]];
  logic [63:0] exp_rdata;
  logic        exp_err;

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(2), .INIT_ZERO(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[0]), .req_ready_o(rdy_v[0]),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(val_v[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata_v[0]),
    .rsp_err_o(err_v[0]), .busy_o(busy_v[0]));

  mem_responder #(.DEPTH_WORDS(4096), .LATENCY(0), .INIT_ZERO(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[1]), .req_ready_o(rdy_v[1]),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(val_v[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata_v[1]),
    .rsp_err_o(err_v[1]), .busy_o(busy_v[1]));

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(3), .INIT_ZERO(1)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid[2]), .req_ready_o(rdy_v[2]),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(val_v[2]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rdata_v[2]),
    .rsp_err_o(err_v[2]), .busy_o(busy_v[2]));

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 3;
  endfunction

  function automatic longint unsigned depth_of(input int s);
    return (s == 2) ? 64 : 4096;
  endfunction

  // Reference behaviour of one accepted request: out-of-range -> err, write
  // merges enabled bytes and returns 0, read returns the stored word.
  task automatic model_req(input int s, input logic we, input logic [7:0] be,
                           input logic [63:0] addr, input logic [63:0] wd);
    longint unsigned widx;
    bit [62:0]       key;
    logic [63:0]     cur;
    widx = addr >> 3;
    if (widx >= depth_of(s)) begin
      exp_err   = 1'b1;
      exp_rdata = 64'h0;
    end else begin
      key = {2'(s), 61'(widx)};
      cur = mdl.exists(key) ? mdl[key] : 64'h0;
      exp_err = 1'b0;
      if (we) begin
        for (int b = 0; b < 8; b++) if (be[b]) cur[8*b +: 8] = wd[8*b +: 8];
        mdl[key]  = cur;
        exp_rdata = 64'h0;
      end else begin
        exp_rdata = cur;
      end
    end
  endtask

  task automatic send_req(input int s, input logic we, input logic [7:0] be,
                          input logic [63:0] addr, input logic [63:0] wd);
    int n = 0;
    while (rdy_v[s] !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_tests++;
    if (rdy_v[s] !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready dut%0d: req_ready=%b, required 1", s, rdy_v[s]);
    end
    req_valid[s] = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    // Scramble the payload: the latched request must be unaffected.
    req_we = 1'($urandom); req_be = 8'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    model_req(s, we, be, addr, wd);
  endtask

  task automatic wait_rsp(input int s);
    int n = 0;
    while (val_v[s] !== 1'b1 && n < 40) begin
      n_tests++;
      if (busy_v[s] !== 1'b1 || rdy_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_state dut%0d: busy=%b ready=%b, required busy=1 ready=0",
                 s, busy_v[s], rdy_v[s]);
      end
      @(posedge clk); #1; n++;
    end
    n_tests++;
    if (val_v[s] !== 1'b1 || n != lat_of(s)) begin
      n_fail++;
      $display("FAIL latency dut%0d: rsp_valid=%b after %0d cycles, required 1 after %0d",
               s, val_v[s], n, lat_of(s));
    end
  endtask

  task automatic finish_rsp(input int s, input int hold);
    repeat (hold) begin
      n_tests++;
      if (val_v[s] !== 1'b1 || rdata_v[s] !== exp_rdata || err_v[s] !== exp_err || rdy_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold dut%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 s, val_v[s], rdata_v[s], err_v[s], rdy_v[s], exp_rdata, exp_err);
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (rdata_v[s] !== exp_rdata) begin
      n_fail++;
      $display("FAIL rdata dut%0d: got %h, required %h", s, rdata_v[s], exp_rdata);
    end
    n_tests++;
    if (err_v[s] !== exp_err) begin
      n_fail++;
      $display("FAIL err dut%0d: got %b, required %b", s, err_v[s], exp_err);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_tests++;
    if (val_v[s] !== 1'b0 || rdy_v[s] !== 1'b1 || busy_v[s] !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake dut%0d: valid=%b ready=%b busy=%b, required 0 1 0",
               s, val_v[s], rdy_v[s], busy_v[s]);
    end
  endtask

  task automatic txn(input int s, input logic we, input logic [7:0] be,
                     input logic [63:0] addr, input logic [63:0] wd, input int hold);
    send_req(s, we, be, addr, wd);
    wait_rsp(s);
    finish_rsp(s, hold);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (rdy_v[s] !== 1'b1 || val_v[s] !== 1'b0 || busy_v[s] !== 1'b0 ||
          rdata_v[s] !== 64'h0 || err_v[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset dut%0d: ready=%b valid=%b busy=%b rdata=%h err=%b, required 1 0 0 0 0",
                 s, rdy_v[s], val_v[s], busy_v[s], rdata_v[s], err_v[s]);
      end
    end
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 8'hFF, 64'h40, 64'h1122334455667788, 0);
    txn(0, 1'b1, 8'hFF, 64'h48, 64'hCAFE0000BEEF1234, 0);
    txn(0, 1'b0, 8'h00, 64'h40, 64'h0, 0);
    n_tests++;
    if (rdata_v[0] !== 64'h0) begin
      n_fail++;
      $display("FAIL idle_rdata: got %h, required 0", rdata_v[0]);
    end
  endtask

  task automatic test_byte_merge();
    txn(0, 1'b1, 8'h0C, 64'h45, 64'h00000000AABB0000, 0);
    send_req(0, 1'b0, 8'h00, 64'h40, 64'h0);
    wait_rsp(0);
    n_tests++;
    if (rdata_v[0] !== 64'h11223344AABB7788) begin
      n_fail++;
      $display("FAIL byte_merge: got %h, required 11223344aabb7788", rdata_v[0]);
    end
    finish_rsp(0, 0);
    txn(0, 1'b1, 8'h00, 64'h40, 64'hFFFFFFFFFFFFFFFF, 0);
    txn(0, 1'b0, 8'h00, 64'h40, 64'h0, 1);
  endtask

  task automatic test_backpressure();
    send_req(0, 1'b0, 8'h00, 64'h40, 64'h0);
    wait_rsp(0);
    // A competing request is presented while the response is held off.
    req_valid[0] = 1'b1; req_we = 1'b0; req_be = 8'h00; req_addr = 64'h48; req_wdata = 64'h0;
    finish_rsp(0, 5);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    model_req(0, 1'b0, 8'h00, 64'h48, 64'h0);
    n_tests++;
    if (busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL second_accept: busy=%b, required 1", busy_v[0]);
    end
    wait_rsp(0);
    finish_rsp(0, 0);
  endtask

  task automatic test_out_of_range();
    txn(0, 1'b1, 8'hFF, 64'h0, 64'h0123456789ABCDEF, 0);
    txn(0, 1'b1, 8'hFF, 64'h8000, 64'hDEADDEADDEADDEAD, 1);
    txn(0, 1'b0, 8'h00, 64'h0, 64'h0, 0);
    txn(0, 1'b0, 8'h00, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0);
    txn(2, 1'b1, 8'hFF, 64'h1F8, 64'h5555AAAA5555AAAA, 0);
    txn(2, 1'b1, 8'hFF, 64'h200, 64'h1111111111111111, 0);
    txn(2, 1'b0, 8'h00, 64'h1F8, 64'h0, 0);
    txn(2, 1'b0, 8'h00, 64'h0000_0001_0000_0000, 64'h0, 0);
  endtask

  task automatic test_lat0();
    txn(1, 1'b1, 8'hF0, 64'h10, 64'hA5A5A5A5_5A5A5A5A, 0);
    txn(1, 1'b0, 8'h00, 64'h13, 64'h0, 2);
  endtask

  task automatic test_reset_mid();
    txn(2, 1'b1, 8'hFF, 64'h80, 64'h0BADF00D_12345678, 0);
    req_valid[2] = 1'b1; req_we = 1'b1; req_be = 8'hFF;
    req_addr = 64'h80; req_wdata = 64'hFFFF_EEEE_DDDD_CCCC;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    n_tests++;
    if (busy_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_accept: busy=%b, required 1", busy_v[2]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (busy_v[2] !== 1'b0 || rdy_v[2] !== 1'b1 || val_v[2] !== 1'b0 || rdata_v[2] !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_reset: busy=%b ready=%b valid=%b rdata=%h, required 0 1 0 0",
               busy_v[2], rdy_v[2], val_v[2], rdata_v[2]);
    end
    repeat (5) @(posedge clk);
    #1;
    txn(2, 1'b0, 8'h00, 64'h80, 64'h0, 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) txn(s, 1'b1, 8'hFF, 64'(i) << 3, {$urandom, $urandom}, 0);
      txn(s, 1'b1, 8'hFF, 64'(depth_of(s) - 1) << 3, {$urandom, $urandom}, 0);
      for (int i = 0; i < 25; i++) begin
        int unsigned     r;
        longint unsigned widx;
        logic [63:0]     addr;
        r = $urandom_range(0, 9);
        if (r < 8)       widx = longint'(r);
        else if (r == 8) widx = depth_of(s) - 1;
        else             widx = depth_of(s) + longint'($urandom_range(0, 3)) * 64'h1_0000_0000;
        addr = (64'(widx) << 3) | 64'($urandom_range(0, 7));
        txn(s, 1'($urandom), 8'($urandom), addr, {$urandom, $urandom}, $urandom_range(0, 2));
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 3'b000; req_we = 1'b0; req_be = 8'h00;
    req_addr = 64'h0; req_wdata = 64'h0; rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_byte_merge();
    test_backpressure();
    test_out_of_range();
    test_lat0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
